// File: rtl/pio_pkg.sv
// Shared definitions for the sensor input PIO: register addresses and edge-capture modes.
package pio_pkg;

   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_MODE    = 2'd1;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2,
      EDGE_OFF  = 2'd3
   } edge_mode_e;

endpackage

// File: rtl/pio_debounce_bit.sv
// Single-bit debounce filter: a change on d is accepted once it has held for
// DEBOUNCE_CYCLES+1 consecutive clocks. q_next exposes the value q takes at the next edge.
module pio_debounce_bit #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic        RESET_VALUE     = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic q_next
);

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign q_next = d;
      end else begin : g_filter
         localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

         logic [CW-1:0] count;
         logic [CW-1:0] count_next;

         // Count consecutive disagreeing samples; accept the new value at the limit.
         always_comb begin
            q_next     = q;
            count_next = '0;
            if (d == q) begin
               count_next = '0;
            end else if (count == CW'(DEBOUNCE_CYCLES)) begin
               q_next     = d;
               count_next = '0;
            end else begin
               count_next = count + CW'(1);
            end
         end

         // Debounce counter state.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               count <= '0;
            end else begin
               count <= count_next;
            end
         end
      end
   endgenerate

   // Stable (accepted) value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= RESET_VALUE;
      end else begin
         q <= q_next;
      end
   end

endmodule

// File: rtl/pio_sense_in.sv
// Debounced, edge-capturing, interrupt-capable Avalon-MM input port.
// Address 0 reads the debounced inputs, matching the legacy input PIO.
module pio_sense_in
   import pio_pkg::*;
#(
   parameter int unsigned      WIDTH           = 8,
   parameter int unsigned      DEBOUNCE_CYCLES = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_next;
   logic [WIDTH-1:0] event_sel;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] edge_cap_next;
   logic [31:0]      rd_mux;
   edge_mode_e       mode;
   logic             wr_en;
   logic             unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   // Two-flop synchroniser for the asynchronous sensor lines.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= RESET_VALUE;
         sync2 <= RESET_VALUE;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   generate
      for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
         pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
         ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (sync2[i]),
            .q       (stable[i]),
            .q_next  (stable_next[i])
         );
      end
   endgenerate

   // Edge events qualified by MODE; they coincide with the stable update.
   always_comb begin
      event_sel = '0;
      unique case (mode)
         EDGE_RISE: event_sel = stable_next & ~stable;
         EDGE_FALL: event_sel = ~stable_next & stable;
         EDGE_ANY:  event_sel = stable_next ^ stable;
         EDGE_OFF:  event_sel = '0;
      endcase
   end

   // Write-1-to-clear capture; a simultaneous new event wins over the clear.
   always_comb begin
      edge_cap_next = edge_cap;
      if (wr_en && address == PIO_ADDR_EDGECAP) begin
         edge_cap_next = edge_cap & ~writedata[WIDTH-1:0];
      end
      edge_cap_next = edge_cap_next | event_sel;
   end

   // Control and capture registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode     <= EDGE_RISE;
         irq_mask <= '0;
         edge_cap <= '0;
      end else begin
         if (wr_en && address == PIO_ADDR_MODE) begin
            mode <= edge_mode_e'(writedata[1:0]);
         end
         if (wr_en && address == PIO_ADDR_IRQMASK) begin
            irq_mask <= writedata[WIDTH-1:0];
         end
         edge_cap <= edge_cap_next;
      end
   end

   // Read address mux; unused bits read as zero.
   always_comb begin
      rd_mux = '0;
      unique case (address)
         PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
         PIO_ADDR_MODE:    rd_mux[1:0]       = mode;
         PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
         PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
      endcase
   end

   // Read data is registered every cycle regardless of chipselect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

   assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_sense_in.sv
// Self-checking bench for pio_sense_in: directed scenarios plus a randomized run
// against a window-based behavioural model of the debounced port.
module tb_pio_sense_in;

   localparam int W = 8;
   localparam int D = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [W-1:0]  in_port;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          irq;

   int checks = 0;
   int errors = 0;

   // Model state: raw samples delayed by two clocks, accepted value, registers.
   logic [W-1:0] m_s1, m_s2, m_stable, m_mask, m_cap;
   logic [1:0]   m_mode;
   logic [31:0]  m_rd;
   logic [W-1:0] m_win[$];

   always #5 clk = ~clk;

   pio_sense_in #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .RESET_VALUE     (8'h00)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_port    (in_port),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   function automatic logic m_irq();
      return |(m_cap & m_mask);
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0; m_cap = '0;
      m_mode = 2'd0; m_rd = '0;
      m_win.delete();
   endtask

   // Advance model one clock from the current inputs, then step the DUT.
   // A bit flips once the last D+1 synchronised samples all disagree with it.
   task automatic tick();
      logic [W-1:0] nstab, ev, sel, w;
      logic         all_diff;
      logic         wr;
      nstab = m_stable;
      m_win.push_back(m_s2);
      if (m_win.size() > D + 1) void'(m_win.pop_front());
      if (m_win.size() == D + 1) begin
         for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < m_win.size(); k++) begin
               w = m_win[k];
               if (w[b] == m_stable[b]) all_diff = 1'b0;
            end
            if (all_diff) nstab[b] = ~m_stable[b];
         end
      end
      ev = nstab ^ m_stable;
      case (m_mode)
         2'd0:    sel = ev & nstab;
         2'd1:    sel = ev & ~nstab;
         2'd2:    sel = ev;
         default: sel = '0;
      endcase
      case (address)
         2'd0:    m_rd = {24'b0, m_stable};
         2'd1:    m_rd = {30'b0, m_mode};
         2'd2:    m_rd = {24'b0, m_mask};
         default: m_rd = {24'b0, m_cap};
      endcase
      wr = chipselect && !write_n;
      if (wr && address == 2'd3) m_cap = m_cap & ~writedata[W-1:0];
      m_cap = m_cap | sel;
      if (wr && address == 2'd1) m_mode = writedata[1:0];
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      m_stable = nstab;
      m_s2 = m_s1;
      m_s1 = in_port;
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input int n);
      repeat (n) tick();
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      tick();
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_port = '0; address = 2'd0;
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: readdata=%h irq=%b expected 0/0", readdata, irq);
      end
      reset_n = 1'b1;
      for (int a = 1; a < 4; a++) begin
         address = 2'(a);
         tick();
         checks++;
         if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_reg%0d: readdata=%h expected 0", a, readdata);
         end
      end
      address = 2'd0;
   endtask

   task automatic test_latency();
      logic [31:0] exp;
      in_port = 8'hA5;
      address = 2'd0;
      for (int e = 1; e <= 22; e++) begin
         tick();
         exp = (e >= 4 + D) ? 32'h0000_00A5 : 32'h0;
         checks++;
         if (readdata !== exp || irq !== 1'b0) begin
            errors++;
            $display("FAIL latency_e%0d: readdata=%h irq=%b expected %h/0", e, readdata, irq, exp);
         end
      end
      address = 2'd3;
      tick();
      checks++;
      if (readdata !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL latency_edgecap: readdata=%h expected 000000a5", readdata);
      end
      bus_write(2'd3, 32'hFF);
      tick();
      checks++;
      if (readdata !== 32'h0) begin
         errors++;
         $display("FAIL latency_clear: readdata=%h expected 0", readdata);
      end
   endtask

   task automatic test_glitch();
      in_port = 8'hA4;
      hold(D + 6);
      bus_write(2'd3, 32'hFF);
      bus_write(2'd2, 32'h01);
      address = 2'd0;
      in_port[0] = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         if (e == 11) in_port[0] = 1'b0;
         tick();
         checks++;
         if (readdata !== 32'h0000_00A4) begin
            errors++;
            $display("FAIL glitch_data_e%0d: readdata=%h expected 000000a4", e, readdata);
         end
      end
      address = 2'd3;
      tick();
      checks++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL glitch_edgecap: readdata=%h irq=%b expected 0/0", readdata, irq);
      end
      in_port[0] = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e == 18) begin
            checks++;
            if (irq !== 1'b0) begin
               errors++;
               $display("FAIL pulse_irq_early: irq=%b expected 0", irq);
            end
         end
         if (e == 19) begin
            checks++;
            if (irq !== 1'b1 || readdata !== 32'h0) begin
               errors++;
               $display("FAIL pulse_e19: irq=%b readdata=%h expected 1/0", irq, readdata);
            end
         end
         if (e == 20) begin
            checks++;
            if (readdata !== 32'h1) begin
               errors++;
               $display("FAIL pulse_edgecap: readdata=%h expected 1", readdata);
            end
         end
      end
      in_port[0] = 1'b0;
      hold(D + 6);
      bus_write(2'd3, 32'hFF);
   endtask

   task automatic test_modes();
      logic exp_rise [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic exp_fall [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int m = 0; m < 4; m++) begin
         bus_write(2'd1, 32'(m));
         bus_write(2'd3, 32'hFF);
         address = 2'd3;
         in_port[0] = 1'b1;
         hold(D + 5);
         checks++;
         if (readdata !== {31'b0, exp_rise[m]} || irq !== exp_rise[m]) begin
            errors++;
            $display("FAIL mode%0d_rise: readdata=%h irq=%b expected %0d/%b",
                     m, readdata, irq, exp_rise[m], exp_rise[m]);
         end
         bus_write(2'd3, 32'hFF);
         in_port[0] = 1'b0;
         hold(D + 5);
         checks++;
         if (readdata !== {31'b0, exp_fall[m]} || irq !== exp_fall[m]) begin
            errors++;
            $display("FAIL mode%0d_fall: readdata=%h irq=%b expected %0d/%b",
                     m, readdata, irq, exp_fall[m], exp_fall[m]);
         end
      end
   endtask

   task automatic test_set_wins();
      bus_write(2'd1, 32'd2);
      bus_write(2'd3, 32'hFF);
      in_port[0] = 1'b1;
      hold(D + 5);
      in_port[0] = 1'b0;
      hold(18);
      // This write lands on the same edge the falling event is accepted.
      address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h01;
      tick();
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      tick();
      checks++;
      if (readdata !== 32'h1 || irq !== 1'b1) begin
         errors++;
         $display("FAIL set_wins: readdata=%h irq=%b expected 1/1", readdata, irq);
      end
      bus_write(2'd3, 32'h01);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL clear_irq: irq=%b expected 0", irq);
      end
      tick();
      checks++;
      if (readdata !== 32'h0) begin
         errors++;
         $display("FAIL clear_edgecap: readdata=%h expected 0", readdata);
      end
   endtask

   task automatic test_mask();
      bus_write(2'd2, 32'h7F);
      bus_write(2'd3, 32'hFF);
      in_port[7] = 1'b0;
      hold(D + 5);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL mask_off: irq=%b expected 0", irq);
      end
      address = 2'd3;
      tick();
      checks++;
      if (readdata !== 32'h80) begin
         errors++;
         $display("FAIL mask_edgecap: readdata=%h expected 80", readdata);
      end
      bus_write(2'd2, 32'hFF);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL mask_on: irq=%b expected 1", irq);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp;
      bus_write(2'd1, 32'd2);
      bus_write(2'd2, 32'hFF);
      in_port = 8'h3C;
      address = 2'd0;
      hold(2 + 8);
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async: readdata=%h irq=%b expected 0/0", readdata, irq);
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         address = (e == 1) ? 2'd1 : (e == 2) ? 2'd3 : (e == 3) ? 2'd2 : 2'd0;
         tick();
         exp = (e >= 4 + D) ? 32'h0000_003C : 32'h0;
         checks++;
         if (readdata !== exp || irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset_e%0d: readdata=%h irq=%b expected %h/0", e, readdata, irq, exp);
         end
      end
   endtask

   task automatic test_random();
      int hold_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold_left == 0) begin
            in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 1) == 1) in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
            hold_left = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12))
                                                    : int'($urandom_range(D + 2, D + 30));
         end
         hold_left--;
         address = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            chipselect = 1'b1;
            write_n = 1'b0;
            writedata = $urandom();
         end else begin
            chipselect = $urandom_range(0, 1) == 1;
            write_n = 1'b1;
            writedata = $urandom();
         end
         tick();
         checks++;
         if (readdata !== m_rd || irq !== m_irq()) begin
            errors++;
            $display("FAIL random_c%0d: readdata=%h irq=%b expected %h/%b",
                     c, readdata, irq, m_rd, m_irq());
         end
      end
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_modes();
      test_set_wins();
      test_mask();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
